prog_loader_ctrl: RTL and testbench
===================================

# prog_loader_ctrl

Framed program-load controller sequencing writes into the 256×16 instruction RAM from the UART byte stream, and gating CPU run mode. Sits between the UART receiver (byte + valid pulse) and the RAM write port. Validates a framed, checksummed image before the CPU may fetch from it. Replaces ad-hoc byte pairing and button-toggled load/run with a deterministic, error-checked protocol.

## Interface
- `TIMEOUT`, default 50000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `rx_byte` input 8: received UART byte, valid only when `rx_valid`=1.
- `rx_valid` input 1: one-cycle pulse per received byte. Consecutive pulses are ≥2 cycles apart.
- `start` input 1: one-cycle run request, used when autorun is compiled out.
- `stop` input 1: one-cycle request to leave run mode and return to loading.
- `mem_we` output 1: RAM write strobe, one cycle per word.
- `mem_addr` output 8: RAM write address, valid when `mem_we`=1.
- `mem_wdata` output 16: RAM write data, {high byte, low byte}.
- `cpu_run` output 1: CPU run enable. High means the RAM is owned by CPU fetch.
- `load_done` output 1: last frame passed checksum.
- `load_err` output 1: last frame failed (checksum or timeout). Sticky.
- `words_loaded` output 9: count of words written in the current/last frame (0–256).

## Operation
- Frame format: SYNC, LEN, ADDR, then LEN words as LO, HI byte pairs, then CHK.
- LEN=0 means 256 words.
- Frame is good iff (LEN + ADDR + all data bytes + CHK) mod 256 == 0, using an 8-bit running sum.
- FSM states: IDLE, LEN, ADDR, DLO, DHI, CHK, DONE, RUN. Transitions below occur on `rx_valid` unless stated.
  - IDLE: byte==SYNC_BYTE → LEN, clearing `load_done`, `load_err`, `words_loaded`, and the running sum. Other bytes are ignored.
  - LEN: latch word counter (0 → 256), add to sum → ADDR.
  - ADDR: latch write pointer, add to sum → DLO.
  - DLO: latch low byte, add to sum → DHI.
  - DHI: next cycle `mem_we`=1, `mem_addr`=pointer, `mem_wdata`={byte, low}. Pointer +1 mod 256, `words_loaded`+1, remaining −1, add to sum. If remaining becomes 0 → CHK, else → DLO.
  - CHK: good sum → DONE with `load_done`=1. Bad sum → IDLE with `load_err`=1.
  - DONE: SYNC byte starts a new frame (→ LEN, `load_done` cleared). Other bytes are ignored. Run entry per Configuration.
  - RUN: `cpu_run`=1. All rx bytes are ignored by this block. `stop` → IDLE with `cpu_run`=0 and `load_done` retained.
- Address wraps 8'hFF → 8'h00 within a frame, with no error.
- Words already written are not rolled back on a bad frame. `cpu_run` can never rise without `load_done`.
- `mem_we` is never asserted in RUN, DONE, or IDLE.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_run`=0, `load_done`=0, `load_err`=0, `words_loaded`=0, state IDLE.
- Write latency: `mem_we` pulses exactly 1 cycle after the `rx_valid` carrying HI. It is a single-cycle pulse.
- Timeout: a 16-bit counter runs in LEN/ADDR/DLO/DHI/CHK and clears on each `rx_valid`.
  - On reaching TIMEOUT: → IDLE, `load_err`=1, no further writes.
  - If `rx_valid` arrives in the same cycle the counter reaches TIMEOUT, the byte wins and the counter clears.
- `cpu_run` rises 1 cycle after entry to RUN and falls 1 cycle after `stop`.
- `start` and `stop` in the same cycle: `stop` wins. In DONE this means no run entry.
- `reset` mid-frame: immediate IDLE, all flags cleared, no pending write issued the following cycle.

## Configuration
- `LOADER_AUTORUN_EN` defined: DONE → RUN automatically on the cycle after the good checksum. `start` is ignored.
- `LOADER_AUTORUN_EN` undefined: DONE holds until a `start` pulse, then → RUN. `start` in any other state is ignored.

## Test plan
- Frame A5,02,10,34,12,78,56,DA → writes [0x10]=0x1234 then [0x11]=0x5678. `load_done`=1, `words_loaded`=2. With autorun, `cpu_run`=1.
- Same frame with CHK=DB → both writes occur, `load_err`=1, `load_done`=0, `cpu_run` stays 0, state IDLE.
- Wrap: A5,02,FF,01,00,02,00,FC → writes [0xFF]=0x0001, [0x00]=0x0002, `load_done`=1.
- Timeout: A5,01,20,11 then silence for TIMEOUT cycles → `load_err`=1, no `mem_we`. A following valid frame clears `load_err`.
- Autorun off: good frame, then `start` → `cpu_run`=1. In RUN, send A5,… → no `mem_we`. `stop` → `cpu_run`=0.
- Reset asserted between LO and HI of word 1 → no `mem_we` afterwards, all outputs return to 0.

Source files
------------

// File: rtl/prog_loader_ctrl.sv
// Framed, checksummed UART program loader for the 256x16 instruction RAM with CPU run gating.
// Build option: define LOADER_AUTORUN_EN to enter run mode automatically after a good frame.
module prog_loader_ctrl #(
  parameter int unsigned TIMEOUT   = 50000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        start,
  input  logic        stop,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_run,
  output logic        load_done,
  output logic        load_err,
  output logic [8:0]  words_loaded
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned TMR_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_DLO, S_DHI, S_CHK, S_DONE, S_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [BYTE_W-1:0]   sum_q, sum_d;
  logic [BYTE_W-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                mem_we_q, mem_we_d;
  logic [BYTE_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic                in_frame_c;
  logic                sync_hit_c;
  logic                timeout_hit_c;
  logic [BYTE_W-1:0]   sum_add_c;

`ifdef LOADER_AUTORUN_EN
  logic unused_start;
  assign unused_start = start;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sum_q       <= '0;
      ptr_q       <= '0;
      lo_q        <= '0;
      rem_q       <= '0;
      tmr_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      lo_q        <= lo_d;
      rem_q       <= rem_d;
      tmr_q       <= tmr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_run_q   <= cpu_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      words_q     <= words_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    lo_d        = lo_q;
    rem_d       = rem_q;
    tmr_d       = '0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    words_d     = words_q;

    in_frame_c    = (state_q == S_LEN) || (state_q == S_ADDR) || (state_q == S_DLO) ||
                    (state_q == S_DHI) || (state_q == S_CHK);
    sync_hit_c    = rx_valid && (rx_byte == SYNC_BYTE);
    sum_add_c     = sum_q + rx_byte;
    timeout_hit_c = 1'b0;

    // Idle-gap counter; a byte arriving when the limit is reached still counts
    if (in_frame_c && !rx_valid) begin
      if (tmr_q == TMR_W'(TIMEOUT)) begin
        timeout_hit_c = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sync_hit_c) begin
          state_d     = S_LEN;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          words_d     = '0;
          sum_d       = '0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          rem_d   = (rx_byte == '0) ? CNT_W'(256) : CNT_W'(rx_byte);
          sum_d   = sum_add_c;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          ptr_d   = rx_byte;
          sum_d   = sum_add_c;
          state_d = S_DLO;
        end
      end
      S_DLO: begin
        if (rx_valid) begin
          lo_d    = rx_byte;
          sum_d   = sum_add_c;
          state_d = S_DHI;
        end
      end
      S_DHI: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = {rx_byte, lo_q};
          ptr_d       = ptr_q + BYTE_W'(1);
          words_d     = words_q + CNT_W'(1);
          rem_d       = rem_q - CNT_W'(1);
          sum_d       = sum_add_c;
          state_d     = (rem_q == CNT_W'(1)) ? S_CHK : S_DLO;
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (sum_add_c == '0) begin
            state_d     = S_DONE;
            load_done_d = 1'b1;
          end else begin
            state_d    = S_IDLE;
            load_err_d = 1'b1;
          end
        end
      end
      S_DONE: begin
`ifdef LOADER_AUTORUN_EN
        if (sync_hit_c) begin
          state_d     = S_LEN;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          words_d     = '0;
          sum_d       = '0;
        end else if (!stop) begin
          state_d = S_RUN;
        end
`else
        if (start && !stop) begin
          state_d = S_RUN;
        end else if (sync_hit_c) begin
          state_d     = S_LEN;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
          words_d     = '0;
          sum_d       = '0;
        end
`endif
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit_c) begin
      state_d    = S_IDLE;
      load_err_d = 1'b1;
    end

    cpu_run_d = (state_d == S_RUN);
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Scoreboard bench for prog_loader_ctrl: random framed images against a frame-level reference model.
module tb_prog_loader_ctrl;

  localparam int unsigned TO = 40;
  localparam logic [7:0]  SYNC = 8'hA5;
`ifdef LOADER_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        start;
  logic        stop;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_err;
  logic [8:0]  words_loaded;

  prog_loader_ctrl #(.TIMEOUT(TO), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .start(start), .stop(stop), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t         sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] dbuf[256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write, on the exact cycle
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=0x%0h data=0x%0h at cycle %0d", mem_addr, mem_wdata, cyc);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", int'(mem_addr), int'(e.a));
        check("write_data", int'(mem_wdata), int'(e.d));
        check("write_cycle", cyc, e.c);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_byte  = $urandom_range(0, 255);
    tick(gap - 1);
  endtask

  task automatic pulse(input logic s_v, input logic p_v);
    start = s_v;
    stop  = p_v;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    tick(2);
  endtask

  // Sends a frame from dbuf; model expects one write per word at (addr+i) mod 256
  task automatic send_frame(input int len, input logic [7:0] addr, input logic [7:0] chk_delta,
                            input bit long_gap);
    logic [7:0] s;
    logic [7:0] len8;
    wr_t        e;
    len8 = 8'(len);
    s    = 8'(len8 + addr);
    send_byte(SYNC, $urandom_range(2, 5));
    send_byte(len8, $urandom_range(2, 5));
    send_byte(addr, long_gap ? int'(TO) + 1 : $urandom_range(2, 5));
    for (int i = 0; i < len; i++) begin
      send_byte(dbuf[i][7:0], $urandom_range(2, 5));
      e.a = 8'((int'(addr) + i) % 256);
      e.d = dbuf[i];
      e.c = cyc + 1;
      sb.push_back(e);
      send_byte(dbuf[i][15:8], $urandom_range(2, 5));
      s = 8'(s + dbuf[i][7:0] + dbuf[i][15:8]);
    end
    send_byte(8'(8'(0) - s + chk_delta), 4);
  endtask

  // Checks frame outcome, then exercises run entry/exit
  task automatic after_frame(input bit good, input int nwords);
    int r;
    tick(3);
    check("load_done", int'(load_done), int'(good));
    check("load_err", int'(load_err), int'(!good));
    check("words_loaded", int'(words_loaded), nwords);
    check("cpu_run_after_frame", int'(cpu_run), int'(good && AUTORUN));
    if (good) begin
      r = $urandom_range(0, 2);
      if (AUTORUN) r = 2;
      if (r == 1) begin
        pulse(1'b1, 1'b1);
        check("start_stop_same_cycle", int'(cpu_run), 0);
      end
      if (r == 2) begin
        if (!AUTORUN) pulse(1'b1, 1'b0);
        check("cpu_run_in_run", int'(cpu_run), 1);
        send_byte(SYNC, 3);
        send_byte(8'h01, 3);
        send_byte(8'h40, 3);
        send_byte(8'h11, 3);
        send_byte(8'h22, 3);
        check("words_in_run", int'(words_loaded), nwords);
        check("cpu_run_held", int'(cpu_run), 1);
        pulse(1'b0, 1'b1);
        check("cpu_run_after_stop", int'(cpu_run), 0);
        check("load_done_after_stop", int'(load_done), 1);
      end
    end else begin
      pulse(1'b1, 1'b0);
      check("start_ignored_idle", int'(cpu_run), 0);
    end
  endtask

  initial begin
    int len;
    bit good;
    logic [7:0] nb;
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; start = 1'b0; stop = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_cpu_run", int'(cpu_run), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_load_err", int'(load_err), 0);
    check("rst_words", int'(words_loaded), 0);

    // Reference frame, then the same with a corrupted checksum
    dbuf[0] = 16'h1234; dbuf[1] = 16'h5678;
    send_frame(2, 8'h10, 8'h00, 1'b0);
    after_frame(1'b1, 2);
    send_frame(2, 8'h10, 8'h01, 1'b0);
    after_frame(1'b0, 2);

    // Address wrap within a frame
    dbuf[0] = 16'h0001; dbuf[1] = 16'h0002;
    send_frame(2, 8'hFF, 8'h00, 1'b0);
    after_frame(1'b1, 2);

    // Timeout mid-word: no write, sticky error, cleared by next good frame
    send_byte(SYNC, 3); send_byte(8'h01, 3); send_byte(8'h20, 3); send_byte(8'h11, 1);
    tick(int'(TO) + 10);
    check("timeout_err", int'(load_err), 1);
    check("timeout_done", int'(load_done), 0);
    check("timeout_words", int'(words_loaded), 0);
    check("timeout_run", int'(cpu_run), 0);
    dbuf[0] = 16'hBEEF;
    send_frame(1, 8'h30, 8'h00, 1'b0);
    after_frame(1'b1, 1);

    // Byte arriving exactly at the timeout limit is accepted
    dbuf[0] = 16'hCAFE; dbuf[1] = 16'h0F0F; dbuf[2] = 16'h7001;
    send_frame(3, 8'h80, 8'h00, 1'b1);
    after_frame(1'b1, 3);

    // Reset between LO and HI: no write, everything back to zero
    send_byte(SYNC, 3); send_byte(8'h01, 3); send_byte(8'h20, 3); send_byte(8'h34, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    send_byte(8'h12, 4);
    check("midrst_mem_addr", int'(mem_addr), 0);
    check("midrst_mem_wdata", int'(mem_wdata), 0);
    check("midrst_done", int'(load_done), 0);
    check("midrst_err", int'(load_err), 0);
    check("midrst_words", int'(words_loaded), 0);
    check("midrst_run", int'(cpu_run), 0);

    // Random frames, including one full 256-word (LEN=0) image
    for (int i = 0; i < 24; i++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == SYNC) nb = 8'h00;
        send_byte(nb, $urandom_range(2, 4));
      end
      len  = (i == 7) ? 256 : $urandom_range(1, 6);
      good = ($urandom_range(0, 3) != 0);
      for (int w = 0; w < len; w++) dbuf[w] = 16'($urandom);
      send_frame(len, 8'($urandom_range(0, 255)), good ? 8'h00 : 8'($urandom_range(1, 255)), 1'b0);
      after_frame(good, len);
    end

    tick(5);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
